// File: rtl/cpu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_ctrl_pkg
// Description : Control-word bit map, exception classes, stage record and
//               MIPS op/funct/rt/rs encodings shared by the decode pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_ctrl_pkg;

  localparam int c_ctrl_w = 13;

  localparam int c_b_memen     = 12;
  localparam int c_b_bal       = 11;
  localparam int c_b_jr        = 10;
  localparam int c_b_jal       = 9;
  localparam int c_b_regwrite  = 8;
  localparam int c_b_regdst    = 7;
  localparam int c_b_alusrc    = 6;
  localparam int c_b_branch    = 5;
  localparam int c_b_memwrite  = 4;
  localparam int c_b_memtoreg  = 3;
  localparam int c_b_jump      = 2;
  localparam int c_b_hilowrite = 1;
  localparam int c_b_cp0write  = 0;

  typedef logic [c_ctrl_w-1:0] ctrl_t;

  localparam ctrl_t c_m_memen     = ctrl_t'(1) << c_b_memen;
  localparam ctrl_t c_m_bal       = ctrl_t'(1) << c_b_bal;
  localparam ctrl_t c_m_jr        = ctrl_t'(1) << c_b_jr;
  localparam ctrl_t c_m_jal       = ctrl_t'(1) << c_b_jal;
  localparam ctrl_t c_m_regwrite  = ctrl_t'(1) << c_b_regwrite;
  localparam ctrl_t c_m_regdst    = ctrl_t'(1) << c_b_regdst;
  localparam ctrl_t c_m_alusrc    = ctrl_t'(1) << c_b_alusrc;
  localparam ctrl_t c_m_branch    = ctrl_t'(1) << c_b_branch;
  localparam ctrl_t c_m_memwrite  = ctrl_t'(1) << c_b_memwrite;
  localparam ctrl_t c_m_memtoreg  = ctrl_t'(1) << c_b_memtoreg;
  localparam ctrl_t c_m_jump      = ctrl_t'(1) << c_b_jump;
  localparam ctrl_t c_m_hilowrite = ctrl_t'(1) << c_b_hilowrite;
  localparam ctrl_t c_m_cp0write  = ctrl_t'(1) << c_b_cp0write;

  // Bits that change architectural state; cleared on an excepting instruction.
  localparam ctrl_t c_m_side_fx = c_m_regwrite | c_m_memen | c_m_memwrite
                                | c_m_hilowrite | c_m_cp0write;

  localparam ctrl_t c_cw_ralu   = c_m_regwrite | c_m_regdst;
  localparam ctrl_t c_cw_muldiv = c_m_regdst | c_m_hilowrite;
  localparam ctrl_t c_cw_mthilo = c_m_hilowrite;
  localparam ctrl_t c_cw_jr     = c_m_jr | c_m_jump;
  localparam ctrl_t c_cw_jalr   = c_m_jr | c_m_regwrite | c_m_regdst;
  localparam ctrl_t c_cw_imm    = c_m_regwrite | c_m_alusrc;
  localparam ctrl_t c_cw_load   = c_m_memen | c_m_regwrite | c_m_alusrc | c_m_memtoreg;
  localparam ctrl_t c_cw_store  = c_m_memen | c_m_alusrc | c_m_memwrite;
  localparam ctrl_t c_cw_branch = c_m_branch;
  localparam ctrl_t c_cw_bal    = c_m_bal | c_m_regwrite | c_m_branch;
  localparam ctrl_t c_cw_j      = c_m_jump;
  localparam ctrl_t c_cw_jal    = c_m_jal | c_m_regwrite;
  localparam ctrl_t c_cw_mfc0   = c_m_regwrite;
  localparam ctrl_t c_cw_mtc0   = c_m_cp0write;

  typedef enum logic [2:0] {
    EXC_NONE    = 3'd0,
    EXC_RI      = 3'd1,
    EXC_SYSCALL = 3'd2,
    EXC_BREAK   = 3'd3,
    EXC_ERET    = 3'd4
  } exc_e;

  typedef struct packed {
    logic  valid;
    exc_e  exc;
    ctrl_t ctrl;
  } stage_rec_t;

  typedef enum logic [1:0] {
    SEL_LOAD   = 2'd0,
    SEL_HOLD   = 2'd1,
    SEL_BUBBLE = 2'd2
  } stage_sel_e;

  // Primary opcodes
  localparam logic [5:0] c_op_special = 6'b000000;
  localparam logic [5:0] c_op_regimm  = 6'b000001;
  localparam logic [5:0] c_op_j       = 6'b000010;
  localparam logic [5:0] c_op_jal     = 6'b000011;
  localparam logic [5:0] c_op_beq     = 6'b000100;
  localparam logic [5:0] c_op_bne     = 6'b000101;
  localparam logic [5:0] c_op_blez    = 6'b000110;
  localparam logic [5:0] c_op_bgtz    = 6'b000111;
  localparam logic [5:0] c_op_addi    = 6'b001000;
  localparam logic [5:0] c_op_addiu   = 6'b001001;
  localparam logic [5:0] c_op_slti    = 6'b001010;
  localparam logic [5:0] c_op_sltiu   = 6'b001011;
  localparam logic [5:0] c_op_andi    = 6'b001100;
  localparam logic [5:0] c_op_ori     = 6'b001101;
  localparam logic [5:0] c_op_xori    = 6'b001110;
  localparam logic [5:0] c_op_lui     = 6'b001111;
  localparam logic [5:0] c_op_cop0    = 6'b010000;
  localparam logic [5:0] c_op_lb      = 6'b100000;
  localparam logic [5:0] c_op_lh      = 6'b100001;
  localparam logic [5:0] c_op_lw      = 6'b100011;
  localparam logic [5:0] c_op_lbu     = 6'b100100;
  localparam logic [5:0] c_op_lhu     = 6'b100101;
  localparam logic [5:0] c_op_sb      = 6'b101000;
  localparam logic [5:0] c_op_sh      = 6'b101001;
  localparam logic [5:0] c_op_sw      = 6'b101011;

  // SPECIAL funct codes
  localparam logic [5:0] c_fn_sll     = 6'b000000;
  localparam logic [5:0] c_fn_srl     = 6'b000010;
  localparam logic [5:0] c_fn_sra     = 6'b000011;
  localparam logic [5:0] c_fn_sllv    = 6'b000100;
  localparam logic [5:0] c_fn_srlv    = 6'b000110;
  localparam logic [5:0] c_fn_srav    = 6'b000111;
  localparam logic [5:0] c_fn_jr      = 6'b001000;
  localparam logic [5:0] c_fn_jalr    = 6'b001001;
  localparam logic [5:0] c_fn_syscall = 6'b001100;
  localparam logic [5:0] c_fn_break   = 6'b001101;
  localparam logic [5:0] c_fn_mfhi    = 6'b010000;
  localparam logic [5:0] c_fn_mthi    = 6'b010001;
  localparam logic [5:0] c_fn_mflo    = 6'b010010;
  localparam logic [5:0] c_fn_mtlo    = 6'b010011;
  localparam logic [5:0] c_fn_mult    = 6'b011000;
  localparam logic [5:0] c_fn_multu   = 6'b011001;
  localparam logic [5:0] c_fn_div     = 6'b011010;
  localparam logic [5:0] c_fn_divu    = 6'b011011;
  localparam logic [5:0] c_fn_add     = 6'b100000;
  localparam logic [5:0] c_fn_addu    = 6'b100001;
  localparam logic [5:0] c_fn_sub     = 6'b100010;
  localparam logic [5:0] c_fn_subu    = 6'b100011;
  localparam logic [5:0] c_fn_and     = 6'b100100;
  localparam logic [5:0] c_fn_or      = 6'b100101;
  localparam logic [5:0] c_fn_xor     = 6'b100110;
  localparam logic [5:0] c_fn_nor     = 6'b100111;
  localparam logic [5:0] c_fn_slt     = 6'b101010;
  localparam logic [5:0] c_fn_sltu    = 6'b101011;
  localparam logic [5:0] c_fn_eret    = 6'b011000;

  // REGIMM rt codes
  localparam logic [4:0] c_rt_bltz    = 5'b00000;
  localparam logic [4:0] c_rt_bgez    = 5'b00001;
  localparam logic [4:0] c_rt_bltzal  = 5'b10000;
  localparam logic [4:0] c_rt_bgezal  = 5'b10001;

  // COP0 rs codes
  localparam logic [4:0] c_rs_mfc0    = 5'b00000;
  localparam logic [4:0] c_rs_mtc0    = 5'b00100;
  localparam logic [4:0] c_rs_co      = 5'b10000;

endpackage
`default_nettype wire

// File: rtl/ctrl_decode_pipe_if.sv
`default_nettype none
// ============================================================================
// Module      : ctrl_decode_pipe_if
// Description : D-stage instruction fields, per-stage stall/flush and the
//               decoded/pipelined control outputs of ctrl_decode_pipe.
// Revision    : 1.0 - initial release
// ============================================================================
interface ctrl_decode_pipe_if #(
  parameter int N_STAGES = 3,
  parameter int CNT_W    = 32
);
  import cpu_ctrl_pkg::*;

  logic                           i_valid_d;
  logic [5:0]                     i_op;
  logic [5:0]                     i_funct;
  logic [4:0]                     i_rs_d;
  logic [4:0]                     i_rt_d;
  logic [N_STAGES-1:0]            i_stall;
  logic [N_STAGES-1:0]            i_flush;
  logic [c_ctrl_w-1:0]            o_ctrl_d;
  logic [2:0]                     o_exc_d;
  logic [c_ctrl_w*N_STAGES-1:0]   o_ctrl_q;
  logic [N_STAGES-1:0]            o_valid_q;
  logic [3*N_STAGES-1:0]          o_exc_q;
  logic                           o_exc_valid;
  logic [2:0]                     o_exc_code;
  logic [CNT_W-1:0]               o_retired;

  modport slave (
    input  i_valid_d, i_op, i_funct, i_rs_d, i_rt_d, i_stall, i_flush,
    output o_ctrl_d, o_exc_d, o_ctrl_q, o_valid_q, o_exc_q,
           o_exc_valid, o_exc_code, o_retired
  );

  modport master (
    output i_valid_d, i_op, i_funct, i_rs_d, i_rt_d, i_stall, i_flush,
    input  o_ctrl_d, o_exc_d, o_ctrl_q, o_valid_q, o_exc_q,
           o_exc_valid, o_exc_code, o_retired
  );

endinterface
`default_nettype wire

// File: rtl/ctrl_stage_reg.sv
`default_nettype none
// ============================================================================
// Module      : ctrl_stage_reg
// Description : One pipeline stage record {valid, exc, ctrl} with
//               load / hold / bubble select.
// Revision    : 1.0 - initial release
// ============================================================================
module ctrl_stage_reg
  import cpu_ctrl_pkg::*;
(
  input  wire logic       clk,
  input  wire logic       rst_n,
  input  wire stage_sel_e i_sel,
  input  wire stage_rec_t i_d,
  output stage_rec_t      o_q
);

  stage_rec_t r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
    end else begin
      case (i_sel)
        SEL_LOAD:   r_q <= i_d;
        SEL_BUBBLE: r_q <= '0;
        default:    r_q <= r_q;
      endcase
    end
  end

  assign o_q = r_q;

endmodule
`default_nettype wire

// File: rtl/ctrl_decode_pipe.sv
`default_nettype none
// ============================================================================
// Module      : ctrl_decode_pipe
// Description : MIPS main decoder plus N_STAGES control pipeline with bubble
//               insertion, exception squash/masking and retire counter.
// Revision    : 1.0 - initial release
// ============================================================================
module ctrl_decode_pipe
  import cpu_ctrl_pkg::*;
#(
  parameter int N_STAGES  = 3,
  parameter int EXC_STAGE = 1,
  parameter int CNT_W     = 32
) (
  input wire logic          clk,
  input wire logic          rst_n,
  ctrl_decode_pipe_if.slave bus
);

  ctrl_t                        w_ctrl_d;
  exc_e                         w_exc_d;
  stage_rec_t                   w_rec_d;
  stage_rec_t                   w_q [N_STAGES];
  logic [N_STAGES-1:0]          w_squash;
  logic                         w_exc_valid;
  logic                         w_retire;
  logic [c_ctrl_w*N_STAGES-1:0] w_ctrl_q;
  logic [N_STAGES-1:0]          w_valid_q;
  logic [3*N_STAGES-1:0]        w_exc_q;
  logic [CNT_W-1:0]             r_retired;

  always_comb begin
    w_ctrl_d = '0;
    w_exc_d  = EXC_NONE;
    if (bus.i_valid_d) begin
      case (bus.i_op)
        c_op_special: begin
          case (bus.i_funct)
            c_fn_sll, c_fn_srl, c_fn_sra, c_fn_sllv, c_fn_srlv, c_fn_srav,
            c_fn_mfhi, c_fn_mflo, c_fn_add, c_fn_addu, c_fn_sub, c_fn_subu,
            c_fn_and, c_fn_or, c_fn_xor, c_fn_nor, c_fn_slt, c_fn_sltu:
              w_ctrl_d = c_cw_ralu;
            c_fn_mult, c_fn_multu, c_fn_div, c_fn_divu:
              w_ctrl_d = c_cw_muldiv;
            c_fn_mthi, c_fn_mtlo: w_ctrl_d = c_cw_mthilo;
            c_fn_jr:              w_ctrl_d = c_cw_jr;
            c_fn_jalr:            w_ctrl_d = c_cw_jalr;
            c_fn_syscall:         w_exc_d  = EXC_SYSCALL;
            c_fn_break:           w_exc_d  = EXC_BREAK;
            default:              w_exc_d  = EXC_RI;
          endcase
        end
        c_op_regimm: begin
          case (bus.i_rt_d)
            c_rt_bltz, c_rt_bgez:     w_ctrl_d = c_cw_branch;
            c_rt_bltzal, c_rt_bgezal: w_ctrl_d = c_cw_bal;
            default:                  w_exc_d  = EXC_RI;
          endcase
        end
        c_op_j:   w_ctrl_d = c_cw_j;
        c_op_jal: w_ctrl_d = c_cw_jal;
        c_op_beq, c_op_bne, c_op_blez, c_op_bgtz:
          w_ctrl_d = c_cw_branch;
        c_op_addi, c_op_addiu, c_op_slti, c_op_sltiu,
        c_op_andi, c_op_ori, c_op_xori, c_op_lui:
          w_ctrl_d = c_cw_imm;
        c_op_lb, c_op_lh, c_op_lw, c_op_lbu, c_op_lhu:
          w_ctrl_d = c_cw_load;
        c_op_sb, c_op_sh, c_op_sw:
          w_ctrl_d = c_cw_store;
        c_op_cop0: begin
          case (bus.i_rs_d)
            c_rs_mfc0: w_ctrl_d = c_cw_mfc0;
            c_rs_mtc0: w_ctrl_d = c_cw_mtc0;
            c_rs_co: begin
              if (bus.i_funct == c_fn_eret) w_exc_d = EXC_ERET;
              else                          w_exc_d = EXC_RI;
            end
            default: w_exc_d = EXC_RI;
          endcase
        end
        default: w_exc_d = EXC_RI;
      endcase
    end
  end

  assign w_rec_d     = {bus.i_valid_d, w_exc_d, w_ctrl_d};
  assign w_exc_valid = w_q[EXC_STAGE].valid && (w_q[EXC_STAGE].exc != EXC_NONE);

  // Everything younger than the excepting stage is turned into a bubble.
  always_comb begin
    w_squash = '0;
    for (int i = 0; i < N_STAGES; i++) begin
      if (i < EXC_STAGE) w_squash[i] = w_exc_valid;
    end
  end

  for (genvar gi = 0; gi < N_STAGES; gi++) begin : g_stage
    stage_rec_t w_up;
    logic       w_up_stall;
    stage_sel_e w_sel;

    if (gi == 0) begin : g_head
      assign w_up       = w_exc_valid ? stage_rec_t'('0) : w_rec_d;
      assign w_up_stall = 1'b0;
    end else begin : g_tail
      assign w_up       = w_q[gi-1];
      assign w_up_stall = bus.i_stall[gi-1];
    end

    always_comb begin
      w_sel = SEL_LOAD;
      if (bus.i_flush[gi] || w_squash[gi]) w_sel = SEL_BUBBLE;
      else if (bus.i_stall[gi])            w_sel = SEL_HOLD;
      else if (w_up_stall)                 w_sel = SEL_BUBBLE;
    end

    ctrl_stage_reg u_reg (
      .clk   (clk),
      .rst_n (rst_n),
      .i_sel (w_sel),
      .i_d   (w_up),
      .o_q   (w_q[gi])
    );
  end

  always_comb begin
    w_ctrl_q  = '0;
    w_valid_q = '0;
    w_exc_q   = '0;
    for (int i = 0; i < N_STAGES; i++) begin
      w_ctrl_q[i*c_ctrl_w +: c_ctrl_w] = w_q[i].ctrl;
      w_valid_q[i]                     = w_q[i].valid;
      w_exc_q[i*3 +: 3]                = w_q[i].exc;
    end
    if (w_exc_valid) begin
      w_ctrl_q[EXC_STAGE*c_ctrl_w +: c_ctrl_w] = w_q[EXC_STAGE].ctrl & ~c_m_side_fx;
    end
  end

  assign w_retire = w_q[N_STAGES-1].valid && !bus.i_stall[N_STAGES-1]
                    && !bus.i_flush[N_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_retired <= '0;
    end else if (w_retire) begin
      r_retired <= r_retired + CNT_W'(1);
    end
  end

  assign bus.o_ctrl_d    = w_ctrl_d;
  assign bus.o_exc_d     = w_exc_d;
  assign bus.o_ctrl_q    = w_ctrl_q;
  assign bus.o_valid_q   = w_valid_q;
  assign bus.o_exc_q     = w_exc_q;
  assign bus.o_exc_valid = w_exc_valid;
  assign bus.o_exc_code  = w_exc_valid ? w_q[EXC_STAGE].exc : EXC_NONE;
  assign bus.o_retired   = r_retired;

endmodule
`default_nettype wire

// File: doc/ctrl_decode_pipe.md
# ctrl_decode_pipe

Parametrised main-decoder and control pipeline for the MIPS core. It decodes op/funct/rs/rt in the D stage into the 13-bit control word and carries it, with a valid bit and an exception class, through `N_STAGES` pipeline registers. Each register has its own stall and flush. Compared with the fixed three-register decoder it replaces, it adds four things:
- automatic bubble insertion at stall boundaries;
- precise exception squash of younger stages;
- side-effect masking of the excepting instruction;
- a retired-instruction counter.

## Interface
Parameters:
- `N_STAGES`, 3: number of post-D stages (0=E, 1=M, 2=W); legal range 2..6.
- `EXC_STAGE`, 1: stage index where exceptions are taken; must be < `N_STAGES`.
- `CNT_W`, 32: width of the retired-instruction counter.

Ports:
- `clk`  in  1  core clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `valid_d`  in  1  D holds a real instruction.
- `op`, `funct`  in  6 each  instruction [31:26], [5:0].
- `rs_d`, `rt_d`  in  5 each  instruction [25:21], [20:16].
- `stall`  in  `N_STAGES`  bit i holds stage i.
- `flush`  in  `N_STAGES`  bit i clears stage i.
- `ctrl_d`  out  13  decoded word, combinational.
- `exc_d`  out  3  decoded exception class, combinational.
- `ctrl_q`  out  13*`N_STAGES`  stage i in bits [13i+12:13i], after side-effect masking.
- `valid_q`  out  `N_STAGES`  per-stage valid.
- `exc_q`  out  3*`N_STAGES`  per-stage exception class.
- `exc_valid`  out  1  exception taken this cycle in `EXC_STAGE`.
- `exc_code`  out  3  class of the taken exception; 0 when `exc_valid`=0.
- `retired`  out  `CNT_W`  count of valid instructions that left the last stage.

## Operation
- Control word bit order, MSB to LSB: memen, bal, jr, jal, regwrite, regdst, alusrc, branch, memwrite, memtoreg, jump, hilowrite, cp0write.
- Exception classes: 0 NONE, 1 RI, 2 SYSCALL, 3 BREAK, 4 ERET.
- Decode classes (bits set; everything else 0):
  - R-ALU, shifts, MFHI/MFLO: regwrite, regdst.
  - MULT/MULTU/DIV/DIVU: regdst, hilowrite.
  - MTHI/MTLO: hilowrite.
  - JR: jr, jump.
  - JALR: jr, regwrite, regdst.
  - SYSCALL: 0, exc SYSCALL. BREAK: 0, exc BREAK.
  - ANDI/ORI/XORI/LUI/ADDI/ADDIU/SLTI/SLTIU: regwrite, alusrc.
  - Loads: memen, regwrite, alusrc, memtoreg.
  - Stores: memen, alusrc, memwrite.
  - BEQ/BNE/BGTZ/BLEZ/BGEZ/BLTZ: branch.
  - BGEZAL/BLTZAL: bal, regwrite, branch.
  - J: jump. JAL: jal, regwrite.
  - MFC0: regwrite. MTC0: cp0write.
  - COP0 with rs=10000 and funct=011000: exc ERET.
- RI cases: unknown op, unknown R-type funct, unknown REGIMM rt, unknown COP0 rs. These give control word 0 and exc RI.
- `valid_d`=0 forces `ctrl_d`=0 and `exc_d`=0.
- Next-state of stage i is evaluated in priority order:
  1. `flush[i]` or internal squash[i] → bubble.
  2. `stall[i]` → hold.
  3. Upstream (D for i=0, otherwise stage i-1) is stalled → bubble.
  4. Otherwise load upstream.
- A bubble is valid=0, ctrl=0, exc=0.
- `exc_valid` = `valid_q[EXC_STAGE]` and `exc_q[EXC_STAGE]`≠0. It is combinational from the register.
- While `exc_valid` is high:
  - internal squash is asserted for stages 0..`EXC_STAGE`-1 and for the D→0 load;
  - regwrite, memen, memwrite, hilowrite and cp0write of stage `EXC_STAGE` are masked to 0 on `ctrl_q`.
- Squash does not apply to `EXC_STAGE` itself; that stage advances normally.
- `retired` increments when the last stage is valid, not stalled, and not flushed. It wraps from all-ones to 0.

## Timing
- Reset values: all stage registers 0, so `ctrl_q`=0, `valid_q`=0 and `exc_q`=0. Also `retired`=0, `exc_valid`=0, `exc_code`=0.
- Reset takes effect asynchronously mid-operation, discarding every in-flight instruction.
- Latency: D to stage i is i+1 edges when there are no stalls.
- Flush and stall together on a stage: flush wins.
- Squash and stall together on a younger stage: squash wins.
- Stalls must be monotone (stall[i] implies stall[j] for j<i). Violating this is undefined; the bench asserts it.

## Structure
- Shared package `cpu_ctrl_pkg` holds:
  - control-bit index constants;
  - the 13-bit width constant;
  - the exception-class enum;
  - op/funct/rt/rs encodings, reusing the existing defines.
- One sub-module, `ctrl_stage_reg`: a single stage record of {valid, exc[2:0], ctrl[12:0]} with hold/load/bubble select. It is instantiated `N_STAGES` times in a generate loop.
- The decoder is an always-comb block in the top module.

## Test plan
- ADDU 0x00221821, `valid_d`=1 → `ctrl_d`=0x180; stage 0 holds 0x180 after 1 edge and stage 2 after 3 edges; `retired` increments 1 edge later.
- LW 0x8C220004 with `stall`=3'b001 for 2 cycles → stage 0 holds 0x1148 for 3 cycles; stage 1 shows 2 bubbles; `retired` never counts bubbles.
- op=6'b111111 followed by two ADDUs → 2 edges later `exc_valid`=1 with `exc_code`=1; stage 0 and the next load are bubbles; stage 1 `ctrl_q` is masked to 0.
- SW 0xAC220000 at M while SYSCALL 0x0000000C is at E, `flush`=3'b001 together with `stall`=3'b001 → stage 0 becomes a bubble; SW ctrl 0x1050 is unaffected.
- Preload `retired`=0xFFFFFFFF by force, retire one instruction → `retired`=0.
- Assert `rst`=0 asynchronously with all stages valid → `valid_q`=0, `ctrl_q`=0 and `retired`=0 before the next edge.
